// File: rtl/decode_sequencer_pkg.sv
// Shared definitions for the decode/encode frame sequencer.
//   - FSM state encoding
//   - bit positions of the stage-enable one-hot vector (C, E, B, A, M, T)
//   - default frame length derived from traceback depth and radix
//   - en_onehot(): maps a state to its stage-enable vector
package decode_sequencer_pkg;

  localparam int TRACEBACK_DEPTH = 32;
  localparam int RADIX           = 4;
  localparam int FRAME_STEPS_DEF = TRACEBACK_DEPTH / RADIX;

  typedef enum logic [2:0] {
    S_IDLE, S_EXT, S_BM, S_ACS, S_MEM, S_TB, S_ENC, S_DONE
  } state_e;

  localparam int NUM_EN = 6;
  localparam int EN_C   = 0;
  localparam int EN_E   = 1;
  localparam int EN_B   = 2;
  localparam int EN_A   = 3;
  localparam int EN_M   = 4;
  localparam int EN_T   = 5;

  function automatic logic [NUM_EN-1:0] en_onehot(state_e s);
    logic [NUM_EN-1:0] v;
    v = '0;
    case (s)
      S_ENC:   v[EN_C] = 1'b1;
      S_EXT:   v[EN_E] = 1'b1;
      S_BM:    v[EN_B] = 1'b1;
      S_ACS:   v[EN_A] = 1'b1;
      S_MEM:   v[EN_M] = 1'b1;
      S_TB:    v[EN_T] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/decode_sequencer_if.sv
// Host/datapath-facing bundle of the sequencer.
//   master: host side, drives start/mode/ack/abort, observes status + enables
//   slave : the sequencer itself
interface decode_sequencer_if #(parameter int CNT_W = 8);
  logic             i_start;
  logic             i_mode_sel;
  logic             i_ack;
  logic             i_abort;
  logic             o_ready;
  logic             o_busy;
  logic             o_done;
  logic             o_mode;
  logic [CNT_W-1:0] o_step;
  logic             o_en_c, o_en_e, o_en_b, o_en_a, o_en_m, o_en_t;

  modport master (
    output i_start, i_mode_sel, i_ack, i_abort,
    input  o_ready, o_busy, o_done, o_mode, o_step,
    input  o_en_c, o_en_e, o_en_b, o_en_a, o_en_m, o_en_t
  );

  modport slave (
    input  i_start, i_mode_sel, i_ack, i_abort,
    output o_ready, o_busy, o_done, o_mode, o_step,
    output o_en_c, o_en_e, o_en_b, o_en_a, o_en_m, o_en_t
  );
endinterface

// File: rtl/decode_sequencer_seq_counter.sv
// seq_counter: loadable down-counter with zero flag.
//   clr_i      synchronous clear (highest priority)
//   load_i     load load_val_i
//   dec_i      decrement, saturating at 0
//   zero_o     count == 0
module seq_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (load_i)               cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/decode_sequencer.sv
// decode_sequencer: job-driven scheduler for the encoder/decoder datapath.
// Accepts one job per start/ack handshake and walks the stage enables:
//   decode: FRAME_STEPS x (EXT,BM,ACS,MEM), then TB for TB_CYCLES, then DONE
//   encode: ENC for ENC_BITS cycles, then DONE
// Ports: clk, rst_n (async, active low), bus (slave modport of
// decode_sequencer_if: start/mode/ack/abort in; ready/busy/done/mode/step and
// the six one-hot stage enables out). All outputs come from registered state.
module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter int FRAME_STEPS = FRAME_STEPS_DEF,
  parameter int TB_CYCLES   = 8,
  parameter int ENC_BITS    = 8,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  decode_sequencer_if.slave   bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             mode_q, mode_d;
  logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [NUM_EN-1:0] en_vec;

  // One counter times both TB and ENC; it is loaded with len-1 on the
  // entering edge so the state lasts exactly len cycles.
  seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    mode_d   = mode_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      S_IDLE: if (bus.i_start) begin
        mode_d = bus.i_mode_sel;
        if (bus.i_mode_sel) begin
          state_d  = S_ENC;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(ENC_BITS - 1);
        end else begin
          state_d  = S_EXT;
        end
      end
      S_EXT: state_d = S_BM;
      S_BM:  state_d = S_ACS;
      S_ACS: state_d = S_MEM;
      S_MEM: if (step_q < CNT_W'(FRAME_STEPS - 1)) begin
        step_d  = step_q + CNT_W'(1);
        state_d = S_EXT;
      end else begin
        step_d   = '0;
        state_d  = S_TB;
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(TB_CYCLES - 1);
      end
      S_TB, S_ENC: if (cnt_zero) state_d = S_DONE;
                   else          cnt_dec = 1'b1;
      S_DONE: if (bus.i_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over everything outside IDLE; in DONE it acts like ack.
    if (state_q != S_IDLE && bus.i_abort) begin
      state_d  = S_IDLE;
      step_d   = '0;
      cnt_clr  = 1'b1;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  always_comb begin
    en_vec      = en_onehot(state_q);
    bus.o_ready = (state_q == S_IDLE);
    bus.o_done  = (state_q == S_DONE);
    bus.o_busy  = (state_q != S_IDLE) && (state_q != S_DONE);
    bus.o_mode  = mode_q;
    bus.o_step  = step_q;
    bus.o_en_c  = en_vec[EN_C];
    bus.o_en_e  = en_vec[EN_E];
    bus.o_en_b  = en_vec[EN_B];
    bus.o_en_a  = en_vec[EN_A];
    bus.o_en_m  = en_vec[EN_M];
    bus.o_en_t  = en_vec[EN_T];
  end
endmodule
